// File: rtl/coef_bank_pingpong.sv
// Ping-pong FIR coefficient store with autonomous tap read sequencer.
// Optional word parity: define CMEM_PARITY_EN.
module coef_bank_pingpong #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cload,
    input  logic [AW-1:0]         caddr,
    input  logic [DATA_WIDTH-1:0] cin,
    input  logic                  swap_req,
    input  logic [AW:0]           ntaps,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [AW-1:0]         tap_idx,
    output logic                  rd_busy,
    output logic                  readco_done,
    output logic                  active_bank,
    output logic                  swap_pending,
    output logic                  cfg_err,
    output logic                  par_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

`ifdef CMEM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);

    logic [MW-1:0] mem [0:2*DEPTH-1];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic [0:0]    state;
    logic [AW-1:0] count;
    logic [AW:0]   ntaps_q;
    logic          last;
    logic          legal;

`ifdef CMEM_PARITY_EN
    assign wr_word = {^cin, cin};
`else
    assign wr_word = cin;
`endif

    // Host writes always land in the bank not currently being read
    always_ff @(posedge clk) begin
        if (cload)
            mem[{~active_bank, caddr}] <= wr_word;
    end

    assign rd_word = mem[{active_bank, count}];
    assign last    = ({1'b0, count} + 1'b1) == ntaps_q;
    assign legal   = (ntaps != '0) && (ntaps <= NMAX);
    assign rd_busy = (state == S_READ);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            count        <= '0;
            ntaps_q      <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            tap_idx      <= '0;
            readco_done  <= 1'b0;
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            readco_done <= 1'b0;
            cfg_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (swap_req)
                        active_bank <= ~active_bank;
                    if (start) begin
                        if (legal) begin
                            state   <= S_READ;
                            count   <= '0;
                            ntaps_q <= ntaps;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    data_out   <= rd_word[DATA_WIDTH-1:0];
                    tap_idx    <= count;
                    data_valid <= 1'b1;
                    count      <= count + 1'b1;
                    // Deferred swap lands on the sequence boundary
                    if (last) begin
                        readco_done <= 1'b1;
                        state       <= S_IDLE;
                        if (swap_req || swap_pending) begin
                            active_bank  <= ~active_bank;
                            swap_pending <= 1'b0;
                        end
                    end else if (swap_req) begin
                        swap_pending <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CMEM_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            par_err <= 1'b0;
        else
            par_err <= (state == S_READ) && (^rd_word);
    end
`else
    assign par_err = 1'b0;
`endif

endmodule
